// File: rtl/pipe_stage_hs.sv
// rtl/pipe_stage_hs.sv - parametrised valid/ready pipeline stage register with skid, flush and stall counter
//
// Purpose:
//   Generic stage register for the processor pipe (D->E, E->M, M->W). It carries WIDTH
//   payload bits from one stage to the next behind a valid/ready handshake. An optional
//   two-entry skid buffer makes in_ready a pure register output. A synchronous flush kills
//   every held beat. A saturating counter records the cycles in which downstream back-pressure
//   held a valid beat.
//
// Parameters:
//   WIDTH      payload width in bits
//   KILL_MASK  payload bits forced to 0 on out_data_o while out_valid_o=0
//   SKID       1: main+skid entries, in_ready_o registered; 0: main only, in_ready_o combinational
//   CNT_W      stall counter width
//
// Ports:
//   clk_i        in   rising-edge clock
//   rst_i        in   asynchronous reset, active-high
//   in_valid_i   in   upstream beat present
//   in_ready_o   out  stage can accept a beat this cycle
//   in_data_i    in   upstream payload
//   flush_i      in   synchronous kill of all held beats
//   out_valid_o  out  beat present on out_data_o
//   out_ready_i  in   downstream accepts the beat this cycle
//   out_data_o   out  payload, KILL_MASK bits zeroed while out_valid_o=0
//   stall_cnt_o  out  saturating count of cycles with out_valid_o=1 and out_ready_i=0

module pipe_stage_hs #(
  parameter int unsigned       WIDTH     = 12,
  parameter logic [WIDTH-1:0]  KILL_MASK = {WIDTH{1'b1}},
  parameter int unsigned       SKID      = 1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // Occupancy states. FULL is only reachable when the skid entry exists.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic accept;
  logic emit;

  // The main entry always holds the oldest beat, so the output is taken straight from it.
  assign out_valid_o = (state_q != ST_EMPTY);

  // While no beat is presented, the kill mask hides stale control bits such as write enables,
  // so downstream logic never sees them even if it ignores out_valid_o.
  assign out_data_o = out_valid_o ? main_q : (main_q & ~KILL_MASK);

  generate
    if (SKID != 0) begin : g_skid
      // Decoded from the state register only, which breaks the ready path to downstream.
      assign in_ready_o = (state_q != ST_FULL);
    end else begin : g_noskid
      // A single entry may be refilled in the same cycle it drains.
      assign in_ready_o = !out_valid_o || out_ready_i;
    end
  endgenerate

  assign accept = in_valid_i && in_ready_o;
  assign emit   = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush_i) begin
      // Flush outranks any handshake: a beat offered this cycle is dropped, and the
      // killed beat keeps only its non-masked bits so the bubble carries no side effects.
      state_d = ST_EMPTY;
      main_d  = main_q & ~KILL_MASK;
      skid_d  = '0;
    end else if (SKID != 0) begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_BUSY;
            main_d  = in_data_i;
          end
        end
        ST_BUSY: begin
          if (accept && emit) begin
            main_d = in_data_i;
          end else if (accept) begin
            // Downstream stalled after in_ready was already promised: park the beat.
            state_d = ST_FULL;
            skid_d  = in_data_i;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (emit) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end else begin
      if (accept) begin
        state_d = ST_BUSY;
        main_d  = in_data_i;
      end else if (emit) begin
        state_d = ST_EMPTY;
      end
    end
  end

  // A flushed beat is not a stall: the hazard unit killed it rather than downstream refusing it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_o && !out_ready_i && !flush_i && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb/tb_pipe_stage_hs.sv - scoreboard bench for pipe_stage_hs (skid and no-skid builds)

module tb_pipe_stage_hs;

  logic clk;
  logic rst;

  // Instance A: skid buffer, kill mask on bits [7:4]
  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [11:0] a_in_data, a_out_data;
  logic [15:0] a_stall;

  // Instance B: no skid, default kill mask, 4-bit stall counter
  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [11:0] b_in_data, b_out_data;
  logic [3:0]  b_stall;

  logic [11:0] qa[$];
  logic [11:0] qb[$];

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_hs #(.WIDTH(12), .KILL_MASK(12'h0F0), .SKID(1), .CNT_W(16)) u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
    .flush_i(a_flush),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .stall_cnt_o(a_stall)
  );

  pipe_stage_hs #(.WIDTH(12), .KILL_MASK(12'hFFF), .SKID(0), .CNT_W(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .flush_i(b_flush),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .stall_cnt_o(b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: sample on the falling edge, where inputs are settled and away from the active edge.
  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL a_unexpected_beat: got 0x%0h, expected no beat", a_out_data);
      end else begin
        logic [11:0] e;
        e = qa.pop_front();
        check("a_beat", 32'(a_out_data), 32'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL b_unexpected_beat: got 0x%0h, expected no beat", b_out_data);
      end else begin
        logic [11:0] e;
        e = qb.pop_front();
        check("b_beat", 32'(b_out_data), 32'(e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic m_valid;
    logic exp_ready;

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_flush = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_flush = 1'b0; b_out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("a_rst_out_valid", 32'(a_out_valid), 32'd0);
    check("a_rst_out_data",  32'(a_out_data),  32'd0);
    check("a_rst_in_ready",  32'(a_in_ready),  32'd1);
    check("a_rst_stall",     32'(a_stall),     32'd0);
    check("b_rst_in_ready",  32'(b_in_ready),  32'd1);
    check("b_rst_stall",     32'(b_stall),     32'd0);

    // Full-rate stream 0x001..0x010: no bubbles, in_ready never drops
    a_out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 12'(i);
      qa.push_back(12'(i));
      step();
      check("a_stream_in_ready",  32'(a_in_ready),  32'd1);
      check("a_stream_out_valid", 32'(a_out_valid), 32'd1);
    end
    a_in_valid = 1'b0;
    step();
    check("a_stream_drained", 32'(a_out_valid), 32'd0);
    check("a_stream_stall",   32'(a_stall),     32'd0);

    // Skid fill: 0x0A, 0x0B, then 0x0C offered while full; three stall edges
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 12'h00A; qa.push_back(12'h00A);
    step();
    a_in_data = 12'h00B; qa.push_back(12'h00B);
    step();
    check("a_full_in_ready",  32'(a_in_ready),  32'd0);
    check("a_full_out_data",  32'(a_out_data),  32'h00A);
    check("a_full_out_valid", 32'(a_out_valid), 32'd1);
    a_in_data = 12'h00C; qa.push_back(12'h00C);
    step();
    step();
    check("a_full_stall",    32'(a_stall),    32'd3);
    check("a_full_in_ready2", 32'(a_in_ready), 32'd0);
    a_out_ready = 1'b1;
    step();
    step();
    a_in_valid = 1'b0;
    step();
    check("a_skid_drained", 32'(a_out_valid), 32'd0);
    check("a_skid_stall",   32'(a_stall),     32'd3);

    // Flush while FULL, with 0xFFF offered the same cycle
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 12'h123;
    step();
    a_in_data = 12'h456;
    step();
    a_flush = 1'b1; a_in_data = 12'hFFF;
    step();
    a_flush = 1'b0; a_in_valid = 1'b0;
    check("a_flush_out_valid", 32'(a_out_valid), 32'd0);
    check("a_flush_out_data",  32'(a_out_data),  32'h103);
    check("a_flush_in_ready",  32'(a_in_ready),  32'd1);
    check("a_flush_stall",     32'(a_stall),     32'd4);
    a_out_ready = 1'b1;
    step();
    check("a_flush_stays_empty", 32'(a_out_valid), 32'd0);
    a_in_valid = 1'b1; a_in_data = 12'h777; qa.push_back(12'h777);
    step();
    a_in_valid = 1'b0;
    step();
    check("a_bubble_masked", 32'(a_out_data), 32'h707);

    // Asynchronous reset pulse between edges while FULL
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 12'h0E1;
    step();
    a_in_data = 12'h0E2;
    step();
    a_in_valid = 1'b0;
    rst = 1'b1;
    #2;
    check("a_midrst_out_valid", 32'(a_out_valid), 32'd0);
    check("a_midrst_out_data",  32'(a_out_data),  32'd0);
    check("a_midrst_in_ready",  32'(a_in_ready),  32'd1);
    check("a_midrst_stall",     32'(a_stall),     32'd0);
    rst = 1'b0;
    #1;
    a_in_valid = 1'b1; a_in_data = 12'h0E3; qa.push_back(12'h0E3);
    a_out_ready = 1'b1;
    step();
    check("a_postrst_accept", 32'(a_out_valid), 32'd1);
    a_in_valid = 1'b0;
    step();

    // B: stall counter saturation at 15 with a 4-bit counter
    b_in_valid = 1'b1; b_in_data = 12'h5A5; b_out_ready = 1'b1; qb.push_back(12'h5A5);
    step();
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 14) check("b_stall_14", 32'(b_stall), 32'd14);
      if (k == 15) check("b_stall_15", 32'(b_stall), 32'd15);
    end
    check("b_stall_sat",    32'(b_stall),    32'd15);
    check("b_stall_in_rdy", 32'(b_in_ready), 32'd0);
    b_out_ready = 1'b1;
    step();
    check("b_drain_valid", 32'(b_out_valid), 32'd0);
    check("b_drain_data",  32'(b_out_data),  32'd0);
    check("b_drain_stall", 32'(b_stall),     32'd15);

    // B: random valid/ready, combinational in_ready against a one-bit occupancy model
    m_valid = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      b_in_valid  = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
      b_in_data   = 12'($urandom);
      #1;
      exp_ready = !m_valid || b_out_ready;
      check("b_rand_in_ready",  32'(b_in_ready),  32'(exp_ready));
      check("b_rand_out_valid", 32'(b_out_valid), 32'(m_valid));
      if (b_in_valid && exp_ready) begin
        qb.push_back(b_in_data);
        m_valid = 1'b1;
      end else if (m_valid && b_out_ready) begin
        m_valid = 1'b0;
      end
      step();
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;

    for (int k = 0; k < 20 && (qa.size() != 0 || qb.size() != 0); k++) begin
      step();
    end
    check("a_queue_empty", 32'(qa.size()), 32'd0);
    check("b_queue_empty", 32'(qb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
